// File: rtl/systolic_pkg.sv
// Shared constants and controller state encoding for the 2x2 systolic array sequencer.
package systolic_pkg;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD0,
    LOAD1,
    SWITCH,
    STREAM,
    DRAIN
  } ctrl_state_t;
endpackage

// File: rtl/systolic_ctrl_result_fifo.sv
// Result FIFO holding deskewed {col1, col2} beats; simultaneous push/pop allowed full or empty.
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0] wptr, rptr;
  logic full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  overflow_chk: assert property (@(posedge clk) disable iff (!rst) !(push && full && !pop));
endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for the 2x2 systolic array: weight load, switch, skewed row issue,
// south-edge deskew into a credit-protected result FIFO.
module systolic_ctrl #(
  parameter int DATA_W     = systolic_pkg::DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DATA_W-1:0] w_00,
  input  logic [DATA_W-1:0] w_01,
  input  logic [DATA_W-1:0] w_10,
  input  logic [DATA_W-1:0] w_11,
  input  logic              x_valid,
  output logic              x_ready,
  input  logic [DATA_W-1:0] x_0,
  input  logic [DATA_W-1:0] x_1,
  input  logic              x_last,
  output logic              y_valid,
  input  logic              y_ready,
  output logic [DATA_W-1:0] y_0,
  output logic [DATA_W-1:0] y_1,
  output logic              y_last,
  output logic              busy,
  output logic              err,
  output logic              sys_accept_w_in,
  output logic              sys_switch_in,
  output logic              sys_start,
  output logic [DATA_W-1:0] sys_weight_in_11,
  output logic [DATA_W-1:0] sys_weight_in_12,
  output logic [DATA_W-1:0] sys_data_in_11,
  output logic [DATA_W-1:0] sys_data_in_21,
  input  logic [DATA_W-1:0] sys_data_out_21,
  input  logic [DATA_W-1:0] sys_data_out_22,
  input  logic              sys_valid_out_21,
  input  logic              sys_valid_out_22
);
  import systolic_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);

  ctrl_state_t state, state_n;

  logic [DATA_W-1:0]   top0, top1, hold, skew;
  logic [AW:0]         in_flight, fifo_count;
  logic [AW+1:0]       credit_used;
  logic [CNT_W-1:0]    issue_cnt, out_cnt, n_rows;
  logic [2*DATA_W-1:0] fifo_rdata;
  logic                last_seen, hold_v, err_r, fifo_empty;
  logic                w_hs, x_hs, push, pop, last_beat;

  assign credit_used = {1'b0, in_flight} + {1'b0, fifo_count};
  assign w_ready     = rst && (state == IDLE);
  assign x_ready     = (state == STREAM) && (credit_used < (AW+2)'(FIFO_DEPTH));
  assign w_hs        = w_valid && w_ready;
  assign x_hs        = x_valid && x_ready;
  assign busy        = (state != IDLE);
  assign err         = err_r;

  assign y_valid   = !fifo_empty;
  assign y_0       = y_valid ? fifo_rdata[2*DATA_W-1:DATA_W] : '0;
  assign y_1       = y_valid ? fifo_rdata[DATA_W-1:0] : '0;
  assign y_last    = y_valid && last_seen && (out_cnt == n_rows - CNT_W'(1));
  assign pop       = y_valid && y_ready;
  assign last_beat = pop && y_last;
  assign push      = sys_valid_out_22 && hold_v;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (w_hs) state_n = LOAD0;
      LOAD0:   state_n = LOAD1;
      LOAD1:   state_n = SWITCH;
      SWITCH:  state_n = STREAM;
      STREAM:  if (x_hs && x_last) state_n = DRAIN;
      DRAIN:   if (last_beat) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Bottom row goes out straight from the ports on the handshake edge, so only
  // the top row needs holding until LOAD1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      top0 <= '0;
      top1 <= '0;
    end else if (w_hs) begin
      top0 <= w_00;
      top1 <= w_01;
    end
  end

  // Array-facing controls are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sys_accept_w_in  <= 1'b0;
      sys_switch_in    <= 1'b0;
      sys_weight_in_11 <= '0;
      sys_weight_in_12 <= '0;
      sys_start        <= 1'b0;
      sys_data_in_11   <= '0;
      sys_data_in_21   <= '0;
      skew             <= '0;
    end else begin
      sys_accept_w_in  <= (state_n == LOAD0) || (state_n == LOAD1);
      sys_switch_in    <= (state_n == SWITCH);
      sys_weight_in_11 <= (state_n == LOAD0) ? w_10 : (state_n == LOAD1) ? top0 : '0;
      sys_weight_in_12 <= (state_n == LOAD0) ? w_11 : (state_n == LOAD1) ? top1 : '0;
      sys_start        <= x_hs;
      sys_data_in_11   <= x_hs ? x_0 : '0;
      skew             <= x_hs ? x_1 : '0;
      sys_data_in_21   <= skew;
    end
  end

  // Column 1 lands one cycle ahead of column 2; hold it until its partner arrives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold      <= '0;
      hold_v    <= 1'b0;
      err_r     <= 1'b0;
      in_flight <= '0;
    end else begin
      if (sys_valid_out_21) hold <= sys_data_out_21;
      hold_v    <= sys_valid_out_21 || (hold_v && !sys_valid_out_22);
      if (sys_valid_out_22 && !hold_v) err_r <= 1'b1;
      in_flight <= in_flight + (AW+1)'(x_hs) - (AW+1)'(push);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_cnt <= '0;
      out_cnt   <= '0;
      n_rows    <= '0;
      last_seen <= 1'b0;
    end else if (last_beat) begin
      issue_cnt <= '0;
      out_cnt   <= '0;
      last_seen <= 1'b0;
    end else begin
      if (pop) out_cnt <= out_cnt + CNT_W'(1);
      if (x_hs) begin
        issue_cnt <= issue_cnt + CNT_W'(1);
        if (x_last) begin
          last_seen <= 1'b1;
          n_rows    <= issue_cnt + CNT_W'(1);
        end
      end
    end
  end

  result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2*DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({hold, sys_data_out_22}),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty)
  );
endmodule
